latch_write_arbiter: RTL and testbench
======================================

// Module: latch_write_arbiter
// PURPOSE
//   Shares one level-sensitive D-latch bank (D/En/Q) between NREQ requesters.
//   Arbitrates requests and captures the winner's data word.
//   Sequences the write as setup, enable pulse, then hold, so D is stable
//   while En is high. Sits between requester logic and the dff latch instance.
// PARAMETERS
//   NREQ          4  number of requesters (>=2)
//   DW            8  data width of latch bank
//   SETUP_CYCLES  1  cycles latch_d is stable before latch_en rises (>=1)
//   EN_CYCLES     2  cycles latch_en is held high (>=1)
//   HOLD_CYCLES   1  cycles latch_d is held after latch_en falls (>=1)
// PORTS
//   clk       in   1        single clock, rising edge
//   rst       in   1        synchronous reset, active-high
//   req       in   NREQ     request vector, level; held until done
//   din       in   NREQ*DW  requester data, slice i = din[i*DW +: DW]
//   gnt       out  NREQ     one-hot grant
//   done      out  NREQ     one-cycle completion pulse to the granted requester
//   latch_d   out  DW       drives latch D
//   latch_en  out  1        drives latch En
//   busy      out  1        high in any state other than IDLE
// BEHAVIOUR
//   - Reset: state=IDLE; gnt, done, latch_d, latch_en, busy all 0; RR ptr=NREQ-1.
//   - All outputs are registered.
//   - FSM: IDLE -> SETUP -> ENABLE -> HOLD -> DONE -> IDLE.
//   - IDLE: if |req at edge k, register the winner W: gnt=onehot(W), latch_d=din[W],
//     busy=1, go to SETUP. If req=0, stay in IDLE.
//   - SETUP: SETUP_CYCLES cycles with latch_en=0.
//   - ENABLE: EN_CYCLES cycles with latch_en=1.
//   - HOLD: HOLD_CYCLES cycles with latch_en=0; latch_d unchanged.
//   - DONE: 1 cycle with done[W]=1. Next edge: IDLE, gnt=0, busy=0, done=0.
//     latch_d keeps its last value.
//   - latch_d is captured once at grant. din changes during the op are ignored.
//   - A req dropped mid-op is ignored: the op completes and done pulses.
//   - Latency: done is high in cycle k+SETUP+EN+HOLD+1. Defaults: 5 cycles after req.
//   - At least one IDLE cycle separates operations; no arbitration in DONE.
//   - A phase counter is sized $clog2 of max(SETUP,EN,HOLD)+1. It is reloaded on
//     each phase entry and never wraps.
//   - Reset mid-operation takes effect at the next edge: IDLE, latch_en=0, no done.
//   - Undefined/X req bits are not tolerated; the bench must drive 0/1 only.
// CONFIGURATION
//   RR_ARB_EN defined:
//     - Round-robin arbitration.
//     - Search starts at ptr+1 mod NREQ; ptr=W on grant.
//     - No requester waits more than NREQ-1 ops.
//   RR_ARB_EN undefined:
//     - Fixed priority: lowest index wins.
//     - No pointer register is built.
// TESTING
//   1 rst=1 for 2 cycles, random req -> gnt=0, done=0, latch_en=0, latch_d=0, busy=0.
//   2 req=0001, din0=8'hA5 at k ->
//       gnt=0001 and latch_d=A5 from k+1;
//       latch_en=1 in cycles k+2..k+3;
//       done=0001 in k+5; gnt=0 at k+6.
//   3 req=1111 held, RR_ARB_EN defined -> grant order 0,1,2,3,0.
//     Same, RR_ARB_EN undefined -> gnt=0001 every op.
//   4 req=0100, din2=8'h3C, din2 changed to 8'hFF during ENABLE -> latch_d stays 3C.
//   5 rst=1 pulse during ENABLE ->
//       latch_en=0, gnt=0, busy=0 after that edge;
//       no done pulse; next req is granted normally.
//   6 req=0010 dropped after grant -> op completes, done=0010 in k+5, then IDLE.

Source files
------------

// File: rtl/latch_write_arbiter.sv
// ============================================================================
// Module   : latch_write_arbiter
// Purpose  : Arbitrates NREQ requesters onto one D-latch bank and sequences each
//            write as setup / enable pulse / hold so D is stable while En is high.
// Config   : define RR_ARB_EN for round-robin arbitration (else fixed priority)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module latch_write_arbiter #(
  parameter int NREQ         = 4,
  parameter int DW           = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int EN_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   din,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [DW-1:0]        latch_d,
  output logic                 latch_en,
  output logic                 busy
);

  localparam int c_MAXC = (SETUP_CYCLES > EN_CYCLES) ?
                          ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                          ((EN_CYCLES > HOLD_CYCLES) ? EN_CYCLES : HOLD_CYCLES);
  localparam int c_CW = $clog2(c_MAXC + 1);
  localparam int c_PW = $clog2(NREQ);

  // Counters load "cycles - 1" and the phase ends when they reach zero.
  localparam logic [c_CW-1:0] c_SETUP_LOAD = c_CW'(SETUP_CYCLES - 1);
  localparam logic [c_CW-1:0] c_EN_LOAD    = c_CW'(EN_CYCLES - 1);
  localparam logic [c_CW-1:0] c_HOLD_LOAD  = c_CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ENABLE = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_CW-1:0]     r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]     r_gnt, w_gnt_nxt;
  logic [NREQ-1:0]     r_done, w_done_nxt;
  logic [DW-1:0]       r_latch_d, w_latch_d_nxt;
  logic                r_latch_en, w_latch_en_nxt;
  logic                r_busy, w_busy_nxt;
  logic                w_win_valid;
  logic [c_PW-1:0]     w_win_idx;

`ifdef RR_ARB_EN
  logic [c_PW-1:0]     r_ptr, w_ptr_nxt;

  // Scan from the farthest offset down so the nearest requester after r_ptr wins.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(r_ptr) + 1 + i) % NREQ]) begin
        w_win_valid = 1'b1;
        w_win_idx   = c_PW'((int'(r_ptr) + 1 + i) % NREQ);
      end
    end
  end
`else
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_win_valid = 1'b1;
        w_win_idx   = c_PW'(i);
      end
    end
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_latch_d_nxt = r_latch_d;
    w_busy_nxt    = r_busy;
`ifdef RR_ARB_EN
    w_ptr_nxt     = r_ptr;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_state_nxt   = S_SETUP;
          w_cnt_nxt     = c_SETUP_LOAD;
          w_gnt_nxt     = {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
          w_latch_d_nxt = din[int'(w_win_idx)*DW +: DW];
          w_busy_nxt    = 1'b1;
`ifdef RR_ARB_EN
          w_ptr_nxt     = w_win_idx;
`endif
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_ENABLE;
          w_cnt_nxt   = c_EN_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_ENABLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = c_HOLD_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
    // Outputs are registered, so they are derived from the state being entered.
    w_latch_en_nxt = (w_state_nxt == S_ENABLE);
    w_done_nxt     = (w_state_nxt == S_DONE) ? w_gnt_nxt : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_latch_d  <= '0;
      r_latch_en <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_done     <= w_done_nxt;
      r_latch_d  <= w_latch_d_nxt;
      r_latch_en <= w_latch_en_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

`ifdef RR_ARB_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= c_PW'(NREQ - 1);
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end
`endif

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign latch_d  = r_latch_d;
  assign latch_en = r_latch_en;
  assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: directed scenarios plus randomized operations
// checked against a timeline/arbitration model of the write sequence.
`default_nettype none

module tb_latch_write_arbiter;
  localparam int NREQ  = 4;
  localparam int DW    = 8;
  localparam int SC    = 1;
  localparam int EC    = 2;
  localparam int HC    = 1;
  localparam int OPLEN = SC + EC + HC + 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  din;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     done;
  logic [DW-1:0]       latch_d;
  logic                latch_en;
  logic                busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_ptr;
  logic [DW-1:0] m_last_d;

  latch_write_arbiter #(
    .NREQ(NREQ), .DW(DW), .SETUP_CYCLES(SC), .EN_CYCLES(EC), .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt), .done(done),
    .latch_d(latch_d), .latch_en(latch_en), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [NREQ-1:0] rq);
    int w;
    w = -1;
`ifdef RR_ARB_EN
    for (int off = NREQ; off >= 1; off--)
      if (rq[(m_ptr + off) % NREQ]) w = (m_ptr + off) % NREQ;
`else
    for (int i = NREQ - 1; i >= 0; i--)
      if (rq[i]) w = i;
`endif
    return w;
  endfunction

  function automatic logic [NREQ*DW-1:0] rand_din();
    logic [NREQ*DW-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // One complete operation, starting and ending at a negedge in IDLE.
  task automatic run_op(input logic [NREQ-1:0] rq, input logic [NREQ*DW-1:0] dv,
                        input int drop_at, input int chg_at,
                        input logic [NREQ*DW-1:0] dv2, input string name);
    int w;
    logic [NREQ-1:0] eg, xg, xdn;
    logic [DW-1:0] ed;
    logic xen, xb;
    w = pick(rq);
    eg = '0;
    eg[w] = 1'b1;
    ed = dv[w*DW +: DW];
`ifdef RR_ARB_EN
    m_ptr = w;
`endif
    req = rq;
    din = dv;
    for (int t = 1; t <= OPLEN; t++) begin
      @(posedge clk);
      @(negedge clk);
      xb  = (t < OPLEN);
      xg  = xb ? eg : '0;
      xen = (t > SC) && (t <= SC + EC);
      xdn = (t == SC + EC + HC + 1) ? eg : '0;
      n_cmp++;
      if ({gnt, done, latch_d, latch_en, busy} !== {xg, xdn, ed, xen, xb}) begin
        n_fail++;
        $display("FAIL %s t=%0d: got gnt=%b done=%b d=%h en=%b busy=%b, expected gnt=%b done=%b d=%h en=%b busy=%b",
                 name, t, gnt, done, latch_d, latch_en, busy, xg, xdn, ed, xen, xb);
      end
      if (t == drop_at) req = '0;
      if (t == chg_at)  din = dv2;
    end
    m_last_d = ed;
  endtask

  task automatic idle_cycles(input int n, input string name);
    req = '0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({gnt, done, latch_d, latch_en, busy} !== {{NREQ{1'b0}}, {NREQ{1'b0}}, m_last_d, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL %s c=%0d: got gnt=%b done=%b d=%h en=%b busy=%b, expected idle with d=%h",
                 name, c, gnt, done, latch_d, latch_en, busy, m_last_d);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      req = NREQ'($urandom);
      din = rand_din();
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({gnt, done, latch_d, latch_en, busy} !== '0) begin
        n_fail++;
        $display("FAIL reset c=%0d: got gnt=%b done=%b d=%h en=%b busy=%b, expected all zero",
                 c, gnt, done, latch_d, latch_en, busy);
      end
    end
    rst = 1'b0;
    req = '0;
    m_ptr = NREQ - 1;
    m_last_d = '0;
  endtask

  task automatic test_single();
    logic [NREQ*DW-1:0] v;
    v = rand_din();
    v[0 +: DW] = 8'hA5;
    run_op(4'b0001, v, 0, 0, v, "single");
    idle_cycles(2, "single_idle");
  endtask

  task automatic test_all_req();
    for (int n = 0; n < 5; n++) run_op(4'b1111, rand_din(), 0, 0, '0, "all_req");
  endtask

  task automatic test_din_change();
    logic [NREQ*DW-1:0] v, v2;
    v = rand_din();
    v[2*DW +: DW] = 8'h3C;
    v2 = v;
    v2[2*DW +: DW] = 8'hFF;
    run_op(4'b0100, v, 0, SC + 1, v2, "din_change");
  endtask

  task automatic test_reset_mid();
    req = 4'b1000;
    din = rand_din();
    for (int c = 0; c < SC + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_cmp++;
    if (latch_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_enable: got en=%b, expected 1", latch_en);
    end
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = NREQ - 1;
    m_last_d = '0;
    n_cmp++;
    if ({gnt, done, latch_d, latch_en, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got gnt=%b done=%b d=%h en=%b busy=%b, expected all zero",
               gnt, done, latch_d, latch_en, busy);
    end
    idle_cycles(OPLEN, "reset_mid_no_done");
    run_op(4'b0010, rand_din(), 0, 0, '0, "after_reset");
  endtask

  task automatic test_drop();
    run_op(4'b0010, rand_din(), 1, 0, '0, "drop");
    idle_cycles(1, "drop_idle");
  endtask

  task automatic test_random();
    logic [NREQ-1:0] rq;
    logic [NREQ*DW-1:0] v;
    for (int n = 0; n < 40; n++) begin
      rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      v  = rand_din();
      run_op(rq, v, int'($urandom_range(0, OPLEN)), int'($urandom_range(1, OPLEN - 1)),
             rand_din(), "random");
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)), "random_gap");
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    din = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_reset();
    test_all_req();
    test_din_change();
    test_reset_mid();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
